// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  localparam int DEPTH_DEFAULT = 32;
  localparam int ADDR_W        = 5;
  localparam int NW_W          = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic err;
    logic core_rst;
  } flags_t;

  // Output flags are a pure function of the state being entered.
  function automatic flags_t flags_of(state_t s);
    flags_t f;
    f.ready    = (s == LOAD) || (s == CHECK);
    f.busy     = (s == LOAD) || (s == CHECK);
    f.done     = (s == DONE);
    f.err      = (s == ERROR);
    f.core_rst = (s == DONE);
    return f;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
  import loader_pkg::*;

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/loader_watchdog.sv
// Idle-cycle counter: flags the cycle in which TIMEOUT idle cycles would be reached.
module loader_watchdog #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst)        count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CW'(1);
  end

  // A clear in the expiry cycle (byte accepted) suppresses the timeout.
  assign expired = enable && !clear && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a little-endian byte stream into instruction memory, verifies an XOR
// checksum, and releases the core reset only on a clean load.
module imem_loader
  import loader_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int DEPTH   = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NW_W-1:0] n_words,
  imem_loader_if.slave    bus,
  output logic            core_rst,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_t          state;
  flags_t          flags;
  logic [NW_W-1:0] n_latched;
  logic [NW_W-1:0] word_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     partial;
  logic [7:0]      checksum;
  logic            accept;
  logic            expired;

  assign accept = bus.byte_valid && flags.ready;

  loader_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept || !flags.ready),
    .enable  (flags.ready),
    .expired (expired)
  );

  assign bus.byte_ready = flags.ready;
  assign busy           = flags.busy;
  assign done           = flags.done;
  assign err            = flags.err;
  assign core_rst       = flags.core_rst;

  // NOTE: every register, including the write address/data, is cleared by the
  // synchronous reset, and all state updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      flags          <= flags_of(IDLE);
      n_latched      <= '0;
      word_idx       <= '0;
      byte_idx       <= '0;
      partial        <= '0;
      checksum       <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            if (n_words == '0 || int'(n_words) > DEPTH) begin
              state <= ERROR;
              flags <= flags_of(ERROR);
            end else begin
              state     <= LOAD;
              flags     <= flags_of(LOAD);
              n_latched <= n_words;
              word_idx  <= '0;
              byte_idx  <= '0;
              checksum  <= '0;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            checksum <= checksum ^ bus.byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= word_idx[ADDR_W-1:0];
              bus.imem_wdata <= {bus.byte_data, partial};
              word_idx       <= word_idx + NW_W'(1);
              if (word_idx == n_latched - NW_W'(1)) begin
                state <= CHECK;
                flags <= flags_of(CHECK);
              end
            end else begin
              // Shift right so the first byte of the word ends up in bits 7:0.
              partial <= {bus.byte_data, partial[23:8]};
            end
          end else if (expired) begin
            state <= ERROR;
            flags <= flags_of(ERROR);
          end
        end
        CHECK: begin
          if (accept) begin
            if (bus.byte_data == checksum) begin
              state <= DONE;
              flags <= flags_of(DONE);
            end else begin
              state <= ERROR;
              flags <= flags_of(ERROR);
            end
          end else if (expired) begin
            state <= ERROR;
            flags <= flags_of(ERROR);
          end
        end
        default: begin
          state <= IDLE;
          flags <= flags_of(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: byte-count reference model plus directed
// and randomized load sequences.
`timescale 1ns/1ps
module tb_imem_loader;
  import loader_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [5:0] n_words = '0;
  logic       core_rst, busy, done, err;

  imem_loader_if bus();

  imem_loader #(.TIMEOUT(TIMEOUT), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_words  (n_words),
    .bus      (bus.slave),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks accepted bytes; writes and verdicts follow from the byte count.
  typedef enum {M_IDLE, M_RUN, M_DONE, M_ERR} mmode_t;
  mmode_t      m_mode = M_IDLE;
  bit          m_valid = 1'b0;
  logic [7:0]  q[$];
  int          m_n = 0;
  int          m_idle = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [36:0] wlog[$];

  task automatic model_step();
    m_we = 1'b0;
    if (!rst) begin
      m_valid = 1'b1;
      m_mode  = M_IDLE;
      q.delete();
      m_idle  = 0;
      m_addr  = '0;
      m_wdata = '0;
    end else if (m_valid) begin
      if (m_mode == M_RUN) begin
        if (bus.byte_valid) begin
          int t;
          q.push_back(bus.byte_data);
          m_idle = 0;
          t = q.size();
          if (t <= 4 * m_n && t % 4 == 0) begin
            m_we    = 1'b1;
            m_addr  = 5'(t / 4 - 1);
            m_wdata = {q[t-1], q[t-2], q[t-3], q[t-4]};
          end
          if (t == 4 * m_n + 1) begin
            logic [7:0] x;
            x = '0;
            for (int i = 0; i < 4 * m_n; i++) x ^= q[i];
            m_mode = (x == q[t-1]) ? M_DONE : M_ERR;
          end
        end else begin
          m_idle++;
          if (m_idle >= TIMEOUT) m_mode = M_ERR;
        end
      end else if (start) begin
        if (n_words == 0 || int'(n_words) > DEPTH) m_mode = M_ERR;
        else begin
          m_mode = M_RUN;
          m_n    = int'(n_words);
          q.delete();
          m_idle = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("byte_ready", bus.byte_ready, m_mode == M_RUN);
      check("busy",       busy,           m_mode == M_RUN);
      check("done",       done,           m_mode == M_DONE);
      check("err",        err,            m_mode == M_ERR);
      check("core_rst",   core_rst,       m_mode == M_DONE);
      check("imem_we",    bus.imem_we,    m_we);
      check("imem_addr",  bus.imem_addr,  m_addr);
      check("imem_wdata", bus.imem_wdata, m_wdata);
      if (bus.imem_we === 1'b1) wlog.push_back({bus.imem_addr, bus.imem_wdata});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int n);
    start   = 1'b1;
    n_words = 6'(n);
    tick();
    start   = 1'b0;
  endtask

  // Idles for gap cycles, then presents b until it is accepted (bounded).
  task automatic send(input logic [7:0] b, input int gap, output bit ok);
    bus.byte_valid = 1'b0;
    repeat (gap) tick();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bit r;
      r = bus.byte_ready;
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    bus.byte_valid = 1'b0;
  endtask

  logic [7:0] prog[8] = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h33, 8'h02, 8'h21, 8'h00};

  task automatic send_prog(input logic [7:0] ck, input int gap, input int long_at);
    bit ok;
    for (int i = 0; i < 8; i++) begin
      send(prog[i], (i == long_at) ? TIMEOUT - 1 : gap, ok);
      check("prog_accept", ok, 1);
    end
    send(ck, gap, ok);
    check("ck_accept", ok, 1);
  endtask

  task automatic check_prog_writes(string tag);
    check({tag, "_nwrites"}, wlog.size(), 2);
    check({tag, "_w0_addr"}, wlog[0][36:32], 0);
    check({tag, "_w0_data"}, wlog[0][31:0], 32'h00500113);
    check({tag, "_w1_addr"}, wlog[1][36:32], 1);
    check({tag, "_w1_data"}, wlog[1][31:0], 32'h00210233);
  endtask

  function automatic int pick_gap();
    return ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
  endfunction

  // mode 0: normal, 1: reset mid-load, 2: stall to timeout, 3: start pulse while loading
  task automatic run_random(int n, bit good, int mode);
    logic [7:0] x;
    logic [7:0] b;
    bit         ok;
    int         cut;
    x   = '0;
    cut = int'($urandom_range(1, 4 * n - 1));
    do_start(n);
    for (int i = 0; i < 4 * n; i++) begin
      if (mode == 1 && i == cut) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        return;
      end
      if (mode == 2 && i == cut) begin
        repeat (TIMEOUT + 2) tick();
        return;
      end
      b = 8'($urandom);
      x ^= b;
      if (mode == 3 && i == cut) begin
        start   = 1'b1;
        n_words = 6'($urandom_range(0, 63));
      end
      send(b, pick_gap(), ok);
      start = 1'b0;
      check("rand_accept", ok, 1);
    end
    send(good ? x : x ^ 8'($urandom_range(1, 255)), pick_gap(), ok);
    check("rand_ck_accept", ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          ok;
    int          edges;
    logic [7:0]  big[128];
    logic [7:0]  x;

    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;

    // Reset state
    rst = 1'b0;
    repeat (2) tick();
    check("rst_byte_ready", bus.byte_ready, 0);
    check("rst_imem_we", bus.imem_we, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_imem_wdata", bus.imem_wdata, 0);
    check("rst_core_rst", core_rst, 0);
    check("rst_flags", {busy, done, err}, 0);
    rst = 1'b1;
    tick();

    // Good two-word load
    wlog.delete();
    do_start(2);
    send_prog(8'h52, 0, -1);
    check("good_done", done, 1);
    check("good_core_rst", core_rst, 1);
    check_prog_writes("good");

    // Bad checksum; also core_rst drops when DONE is left
    wlog.delete();
    do_start(2);
    check("leave_done_core_rst", core_rst, 0);
    check("leave_done_busy", busy, 1);
    send_prog(8'h53, 0, -1);
    check("badck_err", err, 1);
    check("badck_done", done, 0);
    check("badck_core_rst", core_rst, 0);
    check("badck_nwrites", wlog.size(), 2);

    // Timeout after two bytes
    wlog.delete();
    do_start(1);
    send(8'hAA, 0, ok);
    send(8'h55, 0, ok);
    edges = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (err) begin
        edges = k;
        break;
      end
    end
    check("timeout_edges", edges, 16);
    check("timeout_nwrites", wlog.size(), 0);

    // Gapped stream, one byte arriving exactly on the expiry cycle
    wlog.delete();
    do_start(2);
    send_prog(8'h52, 3, 4);
    check("gap_done", done, 1);
    check_prog_writes("gap");

    // Reset after six bytes, then rerun
    wlog.delete();
    do_start(2);
    for (int i = 0; i < 6; i++) send(prog[i], 0, ok);
    rst = 1'b0;
    tick();
    check("midrst_outputs",
          {bus.byte_ready, bus.imem_we, core_rst, busy, done, err}, 0);
    check("midrst_addr", bus.imem_addr, 0);
    check("midrst_wdata", bus.imem_wdata, 0);
    rst = 1'b1;
    repeat (3) tick();
    check("midrst_nwrites", wlog.size(), 1);
    wlog.delete();
    do_start(2);
    send_prog(8'h52, 0, -1);
    check("rerun_done", done, 1);
    check_prog_writes("rerun");

    // Word-count boundaries
    do_start(0);
    check("nw0_err", err, 1);
    check("nw0_busy", busy, 0);
    do_start(33);
    check("nw33_err", err, 1);
    wlog.delete();
    do_start(32);
    x = '0;
    for (int i = 0; i < 128; i++) begin
      big[i] = 8'($urandom);
      x ^= big[i];
      send(big[i], 0, ok);
    end
    tick();
    check("nw32_nwrites", wlog.size(), 32);
    check("nw32_last_addr", wlog[31][36:32], 31);
    check("nw32_last_data", wlog[31][31:0], {big[127], big[126], big[125], big[124]});
    check("nw32_in_check", {busy, bus.byte_ready}, 2'b11);
    send(x, 0, ok);
    check("nw32_done", done, 1);

    // Randomized loads
    for (int it = 0; it < 40; it++) begin
      int mode;
      mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_random(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), mode);
      repeat (2) tick();
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
